// File: rtl/scroll_ctrl.sv
// scroll_ctrl: message scheduler for the 4-digit multiplexed hex display.
// Holds a nibble message buffer and presents a 16-bit, four-character window
// that steps one character left every TICK_DIV clocks. Scrolling is one-shot
// or looping, with start/stop/pause control.
module scroll_ctrl #(
   parameter int         MAX_LEN  = 16,
   parameter int         TICK_DIV = 25000000,
   parameter logic [3:0] PAD_NIB  = 4'h0,
   localparam int        AW       = $clog2(MAX_LEN)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [3:0]    wr_data,
   input  logic [AW:0]   len,
   input  logic          start,
   input  logic          stop,
   input  logic          loop,
   input  logic          pause,
   output logic [15:0]   window,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] pos
);

   localparam int          PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0] TERM_CNT  = PW'(TICK_DIV - 1);
   localparam logic [AW:0]   MAX_LEN_L = (AW + 1)'(MAX_LEN);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] pos_q, pos_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [AW:0]   len_q, len_d;
   logic          loop_q, loop_d;
   logic          done_q, done_d;
   logic [15:0]   window_q, window_d;
   logic [3:0]    buf_q [MAX_LEN];

   logic          start_ok;
   logic          adv;
   logic          tick;
   logic          last_char;
   logic [AW:0]   pos_ext;
   logic [AW:0]   pos_inc;

   logic [AW-1:0] win_pos;
   logic [AW:0]   win_len;
   logic          win_loop;
   logic [AW:0]   idx;
   logic [AW:0]   widx;
   logic [3:0]    nib;

   // Saturate a requested length to the buffer depth.
   function automatic logic [AW:0] clamp_len(input logic [AW:0] l);
      if (l > MAX_LEN_L) return MAX_LEN_L;
      return l;
   endfunction

   // Length used for the idle preview: zero means "whole buffer".
   function automatic logic [AW:0] preview_len(input logic [AW:0] l);
      if (l == '0) return MAX_LEN_L;
      return clamp_len(l);
   endfunction

   // Shared control decodes. stop outranks start, start outranks pause,
   // pause outranks the prescaler tick. HOLD with pause released advances
   // on that same cycle, so the frozen time equals the cycles pause was high.
   assign start_ok  = (state_q == IDLE) && start && !stop && (len != '0);
   assign adv       = (state_q != IDLE) && !stop && !pause;
   assign tick      = adv && (presc_q == TERM_CNT);
   assign pos_ext   = {1'b0, pos_q};
   assign pos_inc   = pos_ext + 1'b1;
   assign last_char = !loop_q && (pos_ext == (len_q - 1'b1));

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state decode.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start_ok) state_d = RUN;
         end
         RUN, HOLD: begin
            if (stop)                   state_d = IDLE;
            else if (pause)             state_d = HOLD;
            else if (tick && last_char) state_d = IDLE;
            else                        state_d = RUN;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs decoded from state.
   always_comb begin
      busy = (state_q != IDLE);
   end

   // Position, prescaler and latched message parameters.
   always_comb begin
      pos_d   = pos_q;
      presc_d = presc_q;
      len_d   = len_q;
      loop_d  = loop_q;
      done_d  = 1'b0;
      if (start_ok) begin
         len_d   = clamp_len(len);
         loop_d  = loop;
         pos_d   = '0;
         presc_d = '0;
      end else if (busy && stop) begin
         pos_d   = '0;
         presc_d = '0;
      end else if (adv) begin
         if (tick) begin
            presc_d = '0;
            if (loop_q) begin
               pos_d = (pos_inc == len_q) ? '0 : pos_inc[AW-1:0];
            end else if (last_char) begin
               pos_d  = '0;
               done_d = 1'b1;
            end else begin
               pos_d = pos_inc[AW-1:0];
            end
         end else begin
            presc_d = presc_q + 1'b1;
         end
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos_q   <= '0;
         presc_q <= '0;
         len_q   <= '0;
         loop_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         pos_q   <= pos_d;
         presc_q <= presc_d;
         len_q   <= len_d;
         loop_q  <= loop_d;
         done_q  <= done_d;
      end
   end

   // Window source: live scroll state when busy, pos=0 one-shot preview when idle.
   always_comb begin
      if (busy) begin
         win_pos  = pos_q;
         win_len  = len_q;
         win_loop = loop_q;
      end else begin
         win_pos  = '0;
         win_len  = preview_len(len);
         win_loop = 1'b0;
      end
   end

   // Assemble the four digits; index math is AW+1 wide so pos+k cannot wrap.
   always_comb begin
      window_d = '0;
      idx      = '0;
      widx     = '0;
      nib      = '0;
      for (int k = 0; k < 4; k++) begin
         idx  = {1'b0, win_pos} + (AW + 1)'(k);
         widx = idx - win_len;
         if (idx < win_len)  nib = buf_q[idx[AW-1:0]];
         else if (win_loop)  nib = buf_q[widx[AW-1:0]];
         else                nib = PAD_NIB;
         window_d[15 - 4*k -: 4] = nib;
      end
   end

   // Message buffer (writable only while idle) and registered window.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < MAX_LEN; i++) buf_q[i] <= 4'h0;
         window_q <= 16'h0000;
      end else begin
         if (wr_en && !busy) buf_q[wr_addr] <= wr_data;
         window_q <= window_d;
      end
   end

   assign window = window_q;
   assign done   = done_q;
   assign pos    = pos_q;

endmodule

// File: tb/tb_scroll_ctrl.sv
// tb_scroll_ctrl: scoreboard bench for scroll_ctrl with TICK_DIV=4, MAX_LEN=16.
module tb_scroll_ctrl;

   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          wr_en = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [3:0]    wr_data = '0;
   logic [AW:0]   len = '0;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic          loop = 1'b0;
   logic          pause = 1'b0;
   logic [15:0]   window;
   logic          busy;
   logic          done;
   logic [AW-1:0] pos;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [15:0] win;
      int          cyc;
   } exp_t;

   exp_t        sb_q[$];
   logic [15:0] prev_win;
   logic [15:0] loop_wins [8];

   always #5 clk = ~clk;

   scroll_ctrl #(
      .MAX_LEN (16),
      .TICK_DIV(4),
      .PAD_NIB (4'h0)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_en  (wr_en),
      .wr_addr(wr_addr),
      .wr_data(wr_data),
      .len    (len),
      .start  (start),
      .stop   (stop),
      .loop   (loop),
      .pause  (pause),
      .window (window),
      .busy   (busy),
      .done   (done),
      .pos    (pos)
   );

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic push_exp(input logic [15:0] w, input int c);
      exp_t e;
      e.win = w;
      e.cyc = c;
      sb_q.push_back(e);
   endtask

   task automatic test_reset();
      repeat (2) step();
      #2 rst_n = 1'b0;
      #1;
      total++; if (window !== 16'h0000) begin bad++; $display("FAIL reset_window got=%h exp=%h", window, 16'h0000); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
      total++; if (pos !== 4'd0) begin bad++; $display("FAIL reset_pos got=%0d exp=0", pos); end
      @(negedge clk);
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_oneshot();
      exp_t e;
      len  = 5'd8;
      loop = 1'b0;
      for (int i = 0; i < 8; i++) begin
         wr_en   = 1'b1;
         wr_addr = AW'(i);
         wr_data = 4'(i + 1);
         step();
      end
      wr_en = 1'b0;
      step();
      total++; if (window !== 16'h1234) begin bad++; $display("FAIL oneshot_preview got=%h exp=%h", window, 16'h1234); end
      prev_win = window;
      sb_q.delete();
      push_exp(16'h2345, 5);  push_exp(16'h3456, 9);  push_exp(16'h4567, 13);
      push_exp(16'h5678, 17); push_exp(16'h6780, 21); push_exp(16'h7800, 25);
      push_exp(16'h8000, 29); push_exp(16'h1234, 33);
      start = 1'b1;
      step();
      start = 1'b0;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL oneshot_busy_start got=%b exp=1", busy); end
      for (int c = 1; c <= 36; c++) begin
         step();
         if (window !== prev_win) begin
            total++;
            if (sb_q.size() == 0) begin
               bad++; $display("FAIL oneshot_extra_change got=%h at cyc=%0d exp=no change", window, c);
            end else begin
               e = sb_q.pop_front();
               if (window !== e.win || c != e.cyc) begin
                  bad++; $display("FAIL oneshot_window got=%h@%0d exp=%h@%0d", window, c, e.win, e.cyc);
               end
            end
            prev_win = window;
         end
         total++; if (done !== (c == 32)) begin bad++; $display("FAIL oneshot_done cyc=%0d got=%b exp=%b", c, done, (c == 32)); end
         total++; if (busy !== (c < 32)) begin bad++; $display("FAIL oneshot_busy cyc=%0d got=%b exp=%b", c, busy, (c < 32)); end
      end
      total++; if (sb_q.size() != 0) begin bad++; $display("FAIL oneshot_missing got=%0d pending exp=0", sb_q.size()); end
   endtask

   task automatic test_loop();
      exp_t e;
      len  = 5'd8;
      loop = 1'b1;
      repeat (2) step();
      prev_win = window;
      sb_q.delete();
      for (int n = 1; n <= 20; n++) push_exp(loop_wins[n % 8], 4 * n + 1);
      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c <= 82; c++) begin
         step();
         if (window !== prev_win) begin
            total++;
            if (sb_q.size() == 0) begin
               bad++; $display("FAIL loop_extra_change got=%h at cyc=%0d exp=no change", window, c);
            end else begin
               e = sb_q.pop_front();
               if (window !== e.win || c != e.cyc) begin
                  bad++; $display("FAIL loop_window got=%h@%0d exp=%h@%0d", window, c, e.win, e.cyc);
               end
            end
            prev_win = window;
         end
         total++; if (done !== 1'b0) begin bad++; $display("FAIL loop_done cyc=%0d got=%b exp=0", c, done); end
      end
      total++; if (sb_q.size() != 0) begin bad++; $display("FAIL loop_missing got=%0d pending exp=0", sb_q.size()); end
      stop = 1'b1;
      step();
      stop = 1'b0;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL loop_stop_busy got=%b exp=0", busy); end
      total++; if (pos !== 4'd0) begin bad++; $display("FAIL loop_stop_pos got=%0d exp=0", pos); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL loop_stop_done got=%b exp=0", done); end
   endtask

   task automatic test_pause_stop();
      exp_t e;
      len  = 5'd8;
      loop = 1'b1;
      repeat (2) step();
      prev_win = window;
      sb_q.delete();
      push_exp(16'h2345, 5);
      push_exp(16'h3456, 19);
      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         step();
         if (window !== prev_win) begin
            total++;
            if (sb_q.size() == 0) begin
               bad++; $display("FAIL pause_extra_change got=%h at cyc=%0d exp=no change", window, c);
            end else begin
               e = sb_q.pop_front();
               if (window !== e.win || c != e.cyc) begin
                  bad++; $display("FAIL pause_window got=%h@%0d exp=%h@%0d", window, c, e.win, e.cyc);
               end
            end
            prev_win = window;
         end
         if (c == 10) begin
            total++; if (busy !== 1'b1) begin bad++; $display("FAIL pause_busy got=%b exp=1", busy); end
         end
         if (c == 17) begin
            total++; if (pos !== 4'd1) begin bad++; $display("FAIL pause_pos_before got=%0d exp=1", pos); end
         end
         if (c == 18) begin
            total++; if (pos !== 4'd2) begin bad++; $display("FAIL pause_pos_tick got=%0d exp=2", pos); end
         end
         if (c == 6)  pause = 1'b1;
         if (c == 16) pause = 1'b0;
      end
      total++; if (sb_q.size() != 0) begin bad++; $display("FAIL pause_missing got=%0d pending exp=0", sb_q.size()); end
      stop  = 1'b1;
      start = 1'b1;
      step();
      stop  = 1'b0;
      start = 1'b0;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL stopstart_busy got=%b exp=0", busy); end
      total++; if (pos !== 4'd0) begin bad++; $display("FAIL stopstart_pos got=%0d exp=0", pos); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL stopstart_done got=%b exp=0", done); end
      step();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL stopstart_busy_later got=%b exp=0", busy); end
   endtask

   task automatic test_ignored();
      len  = 5'd8;
      loop = 1'b1;
      repeat (2) step();
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      wr_en   = 1'b1;
      wr_addr = 4'd0;
      wr_data = 4'hF;
      step();
      wr_en = 1'b0;
      step();
      total++; if (window !== 16'h1234) begin bad++; $display("FAIL ignored_write_run got=%h exp=%h", window, 16'h1234); end
      stop = 1'b1;
      step();
      stop = 1'b0;
      repeat (2) step();
      total++; if (window !== 16'h1234) begin bad++; $display("FAIL ignored_write_idle got=%h exp=%h", window, 16'h1234); end
      len   = 5'd0;
      start = 1'b1;
      step();
      start = 1'b0;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL ignored_len0_busy got=%b exp=0", busy); end
      step();
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL ignored_len0_busy_later got=%b exp=0", busy); end
      total++; if (window !== 16'h1234) begin bad++; $display("FAIL ignored_len0_preview got=%h exp=%h", window, 16'h1234); end
   endtask

   task automatic test_reset_midrun();
      len  = 5'd8;
      loop = 1'b1;
      repeat (2) step();
      start = 1'b1;
      step();
      start = 1'b0;
      for (int c = 1; c <= 21; c++) begin
         step();
         if (c == 20) begin
            total++; if (pos !== 4'd5) begin bad++; $display("FAIL midrun_pos got=%0d exp=5", pos); end
         end
      end
      #2 rst_n = 1'b0;
      #1;
      total++; if (window !== 16'h0000) begin bad++; $display("FAIL midrun_rst_window got=%h exp=%h", window, 16'h0000); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrun_rst_busy got=%b exp=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL midrun_rst_done got=%b exp=0", done); end
      total++; if (pos !== 4'd0) begin bad++; $display("FAIL midrun_rst_pos got=%0d exp=0", pos); end
      @(negedge clk);
      rst_n = 1'b1;
      len   = 5'd4;
      loop  = 1'b0;
      repeat (2) step();
      total++; if (window !== 16'h0000) begin bad++; $display("FAIL midrun_preview got=%h exp=%h", window, 16'h0000); end
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL midrun_restart_busy got=%b exp=1", busy); end
      for (int c = 2; c <= 6; c++) begin
         step();
         total++; if (window !== 16'h0000) begin bad++; $display("FAIL midrun_restart_window cyc=%0d got=%h exp=%h", c, window, 16'h0000); end
      end
   endtask

   initial begin
      loop_wins[0] = 16'h1234; loop_wins[1] = 16'h2345;
      loop_wins[2] = 16'h3456; loop_wins[3] = 16'h4567;
      loop_wins[4] = 16'h5678; loop_wins[5] = 16'h6781;
      loop_wins[6] = 16'h7812; loop_wins[7] = 16'h8123;
      test_reset();
      test_oneshot();
      test_loop();
      test_pause_stop();
      test_ignored();
      test_reset_midrun();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
